// File: rtl/prog_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq_pkg
// Purpose  : Shared types and helpers for the multi-program sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package prog_seq_pkg;

    // Widest entry table the helper can index.
    localparam int c_TBLW = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RUN      = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FINISHED = 3'd4
    } state_t;

    // Per-cycle control action, resolved by fixed priority in RUN.
    typedef enum logic [2:0] {
        CT_INC   = 3'd0,
        CT_STALL = 3'd1,
        CT_HALT  = 3'd2,
        CT_RET   = 3'd3,
        CT_CALL  = 3'd4,
        CT_BABS  = 3'd5,
        CT_BREL  = 3'd6
    } ctrl_t;

    // Caller truncates the result to its own width to obtain entry idx.
    function automatic logic [c_TBLW-1:0] entry_of(input logic [c_TBLW-1:0] tbl,
                                                   input int idx,
                                                   input int w);
        return tbl >> (idx * w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_seq_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : Return-address LIFO with full/empty flags and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Push,
    input  logic         Pop,
    input  logic [W-1:0] DIn,
    output logic [W-1:0] DOut,
    output logic         Full,
    output logic         Empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW:0]   r_cnt;
    logic [c_AW-1:0] w_wr_ptr;
    logic [c_AW-1:0] w_rd_ptr;
    logic            w_do_push;

    assign w_wr_ptr  = r_cnt[c_AW-1:0];
    assign w_rd_ptr  = w_wr_ptr - 1'b1;
    // Depth is a power of two, so the count MSB alone marks "full".
    assign Full      = r_cnt[c_AW];
    assign Empty     = (r_cnt == '0);
    assign DOut      = r_mem[w_rd_ptr];
    assign w_do_push = Push && !Full && !Reset && !Clear;

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            r_cnt <= '0;
        end else if (Push && !Full) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (Pop && !Empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[w_wr_ptr] <= DIn;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq
// Purpose  : Multi-program sequencer driving the instruction ROM address.
// Revision : 1.0 - initial release
// ============================================================================
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int               L      = 10,
    parameter int               NPROG  = 3,
    parameter logic [NPROG*L-1:0] ENTRY = {10'd4, 10'd2, 10'd1},
    parameter int               SDEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Halt,
    input  logic                       Stall,
    input  logic                       BranchAbs,
    input  logic                       BranchRel,
    input  logic                       Call,
    input  logic                       Ret,
    input  logic [L-1:0]               Target,
    output logic [L-1:0]               ProgCtr,
    output logic [$clog2(NPROG+1)-1:0] ProgIdx,
    output logic                       Running,
    output logic                       Done,
    output logic                       AllDone,
    output logic                       StackErr
);

    localparam int              IW     = $clog2(NPROG + 1);
    localparam logic [IW-1:0]   c_LAST = IW'(NPROG - 1);

    state_t        r_state, w_state_nxt;
    ctrl_t         w_ctrl;
    logic [L-1:0]  r_pc, w_pc_nxt, w_pc_inc, w_entry, w_top;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_running, r_done, r_alldone, r_stackerr;
    logic          w_done_nxt, w_err_nxt;
    logic          w_push, w_pop, w_clear, w_full, w_empty;

    assign w_pc_inc = r_pc + 1'b1;
    assign w_entry  = L'(entry_of(c_TBLW'(ENTRY), int'(r_idx), L));

    ret_stack #(
        .W     (L),
        .DEPTH (SDEPTH)
    ) u_stack (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (w_clear),
        .Push  (w_push),
        .Pop   (w_pop),
        .DIn   (w_pc_inc),
        .DOut  (w_top),
        .Full  (w_full),
        .Empty (w_empty)
    );

    always_comb begin
        w_ctrl = CT_INC;
        if (Stall)          w_ctrl = CT_STALL;
        else if (Halt)      w_ctrl = CT_HALT;
        else if (Ret)       w_ctrl = CT_RET;
        else if (Call)      w_ctrl = CT_CALL;
        else if (BranchAbs) w_ctrl = CT_BABS;
        else if (BranchRel) w_ctrl = CT_BREL;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_stackerr;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    w_state_nxt = ST_ARMED;
                    w_pc_nxt    = w_entry;
                    w_clear     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!Start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                case (w_ctrl)
                    CT_STALL: ;
                    CT_HALT: begin
                        w_done_nxt = 1'b1;
                        w_idx_nxt  = r_idx + 1'b1;
                        if (r_idx == c_LAST) begin
                            w_state_nxt = ST_FINISHED;
                            w_pc_nxt    = '0;
                        end else begin
                            w_state_nxt = ST_HALTED;
                        end
                    end
                    CT_RET: begin
                        // Underflow still advances so the program keeps fetching.
                        if (w_empty) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt  = w_top;
                            w_pop     = 1'b1;
                        end
                    end
                    CT_CALL: begin
                        w_pc_nxt = Target;
                        if (w_full) w_err_nxt = 1'b1;
                        else        w_push    = 1'b1;
                    end
                    CT_BABS: w_pc_nxt = Target;
                    CT_BREL: w_pc_nxt = r_pc + Target;
                    default: w_pc_nxt = w_pc_inc;
                endcase
            end
            ST_FINISHED: w_pc_nxt = '0;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_idx      <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_alldone  <= 1'b0;
            r_stackerr <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_idx      <= w_idx_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= w_done_nxt;
            r_alldone  <= (w_state_nxt == ST_FINISHED);
            r_stackerr <= w_err_nxt;
        end
    end

    assign ProgCtr  = r_pc;
    assign ProgIdx  = r_idx;
    assign Running  = r_running;
    assign Done     = r_done;
    assign AllDone  = r_alldone;
    assign StackErr = r_stackerr;

endmodule
`default_nettype wire

// File: doc/prog_seq.md
Name: prog_seq

Overview:
- Parametrised successor to the program counter: multi-program sequencer with a configurable entry-point table, a call/return address stack, stall support and per-program start/done handshake.
- Sits between the instruction decoder/ALU branch logic and instruction ROM; drives the ROM address every cycle.

Parameters:
- L, 10, program counter width in bits
- NPROG, 3, number of programs launched in sequence
- ENTRY, {10'd4,10'd2,10'd1}, packed NPROG*L vector of entry addresses; slice i is program i's entry
- SDEPTH, 4, return-stack depth (power of 2, >=2)

Ports:
- Clk  input  1  clock; all state changes on posedge only
- Reset  input  1  synchronous, active-high reset
- Start  input  1  level; hold high to arm next program, release to commence
- Halt  input  1  decoder reports halt instruction at ProgCtr
- Stall  input  1  freeze PC this cycle (memory wait)
- BranchAbs  input  1  ProgCtr <= Target
- BranchRel  input  1  ProgCtr <= ProgCtr + signed Target
- Call  input  1  push ProgCtr+1, ProgCtr <= Target
- Ret  input  1  ProgCtr <= popped address
- Target  input  L  jump target / signed offset
- ProgCtr  output  L  program counter register
- ProgIdx  output  $clog2(NPROG+1)  index of current/next program
- Running  output  1  high in RUN state
- Done  output  1  one-cycle pulse when a program halts
- AllDone  output  1  high in FINISHED
- StackErr  output  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (synchronous, priority over everything): ProgCtr=0, ProgIdx=0, state IDLE, stack empty, Running=0, Done=0, AllDone=0, StackErr=0.
- States: IDLE, ARMED, RUN, HALTED, FINISHED.
- IDLE/HALTED: ProgCtr held; Start=1 -> ARMED, ProgCtr <= ENTRY[ProgIdx], stack cleared.
- ARMED: ProgCtr held while Start=1; Start=0 -> RUN (first fetch at entry address next cycle). All other control inputs ignored.
- RUN, per cycle, priority Stall > Halt > Ret > Call > BranchAbs > BranchRel > increment:
  - Stall: all state held.
  - Halt: Done pulses next cycle, ProgIdx += 1, ProgCtr held. If ProgIdx was NPROG-1 -> FINISHED, else -> HALTED.
  - Ret: ProgCtr <= top of stack, pop. If stack is empty: ProgCtr <= ProgCtr+1, StackErr <= 1.
  - Call: push ProgCtr+1 (mod 2^L), ProgCtr <= Target. If stack is full: jump taken, push dropped, StackErr <= 1.
  - BranchAbs: ProgCtr <= Target.
  - BranchRel: ProgCtr <= ProgCtr + sign-extended Target, wraps mod 2^L.
  - Otherwise: ProgCtr <= ProgCtr + 1, wraps from 2^L-1 to 0.
- FINISHED: ProgCtr=0, AllDone=1, Start ignored; only Reset exits.
- Start asserted during RUN is ignored.
- Running is registered and equals (state==RUN). Control inputs take effect with 1-cycle latency, i.e. on the next ProgCtr value.
- StackErr clears only on Reset.

Decomposition:
- prog_seq_pkg: state enum (IDLE, ARMED, RUN, HALTED, FINISHED), ctrl priority encoding enum, helper function entry_of(idx).
- Sub-module ret_stack: parametrised LIFO (L wide, SDEPTH deep) with push, pop, full, empty and synchronous clear.

Test Plan:
- Reset, then Start high 2 cycles, then low -> ProgCtr=1 while ARMED, Running=1 the cycle after release, then ProgCtr 2,3,4.
- In RUN at PC=5: Call Target=20 -> PC=20; Ret -> PC=6; Ret again on empty stack -> PC=7, StackErr=1.
- At PC=10: BranchRel Target=10'h3FE (-2) -> PC=8. At PC=1023 with no control -> PC=0.
- Stall=1 with BranchAbs=1, Target=50 for 3 cycles -> PC unchanged; Stall drops with BranchAbs held -> PC=50.
- Five nested Calls with SDEPTH=4 -> 5th jump taken, StackErr=1; four Rets return correct addresses in LIFO order.
- Halt three times with Start pulses between -> programs launch at entries 1, 2, 4; Done pulses 3 times; AllDone=1, PC=0; Reset mid-RUN -> all outputs return to reset values next cycle.
